// File: rtl/keccak_absorb_ctrl_pkg.sv
// Shared types and constants for the Keccak absorb sequencer.
package keccak_absorb_ctrl_pkg;

    localparam int unsigned KeccakErrW = 3;

    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    // Codewords of a [6,3] linear code: every pair differs in at least 3 bits.
    typedef enum logic [5:0] {
        StIdle   = 6'b100110,
        StAbsorb = 6'b010101,
        StRun    = 6'b001011,
        StWait   = 6'b110011,
        StDone   = 6'b101101,
        StError  = 6'b011110
    } absorb_st_e;

endpackage

// File: rtl/keccak_absorb_ctrl.sv
// Sequences a pre-padded word stream into keccak_round: lane writes, run pulses,
// completion wait, digest hand-off, storage clear and error aggregation.
module keccak_absorb_ctrl
    import keccak_absorb_ctrl_pkg::*;
#(
    parameter int unsigned Width      = 1600,
    parameter int unsigned DInWidth   = 64,
    parameter int unsigned TimeoutCyc = 64,
    localparam int unsigned DInEntry  = Width / DInWidth,
    localparam int unsigned DInAddr   = $clog2(DInEntry)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DInAddr-1:0]    block_words_i,
    input  logic                  msg_valid_i,
    input  logic [DInWidth-1:0]   msg_data_i,
    input  logic                  msg_last_i,
    output logic                  msg_ready_o,
    input  logic                  clear_i,
    output logic                  digest_valid_o,
    output logic                  busy_o,
    output logic                  cmd_err_o,
    output logic                  error_o,
    output logic                  keccak_valid_o,
    output logic [DInAddr-1:0]    keccak_addr_o,
    output logic [DInWidth-1:0]   keccak_data_o,
    input  logic                  keccak_ready_i,
    output logic                  keccak_run_o,
    input  logic                  keccak_complete_i,
    output mubi4_t                keccak_clear_o,
    input  logic [KeccakErrW-1:0] keccak_err_i
);

    localparam int unsigned TimerW = $clog2(TimeoutCyc + 1);
    localparam logic [DInAddr:0] MaxRate = (DInAddr + 1)'(DInEntry);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCyc - 1);

    absorb_st_e          st_q;
    logic [DInAddr-1:0]  word_cnt_q;
    logic [DInAddr-1:0]  block_words_q;
    logic [TimerW-1:0]   timer_q;
    logic                last_seen_q;
    logic                cmd_err_q;
    logic                clear_pend_q;

    logic rate_ok;
    logic in_idle;
    logic in_absorb;
    logic clear_window;
    logic clear_req;
    logic accept;
    logic block_end;
    logic cmd_illegal;

    always_comb begin
        rate_ok      = (block_words_i != '0) && ({1'b0, block_words_i} <= MaxRate);
        in_idle      = (st_q == StIdle);
        in_absorb    = (st_q == StAbsorb);
        clear_window = in_idle || (st_q == StDone);
        // A clear that meets keccak_ready_i=0 is held until the core can take it.
        clear_req    = (clear_i && clear_window) || clear_pend_q;
        accept       = in_absorb && keccak_ready_i && msg_valid_i;
        block_end    = accept && ((word_cnt_q == block_words_q - 1'b1) || msg_last_i);
        cmd_illegal  = (start_i && !in_idle)
                    || (start_i && in_idle && (clear_i || clear_pend_q || !rate_ok))
                    || (clear_i && !clear_window);
    end

    always_comb begin
        msg_ready_o    = in_absorb && keccak_ready_i;
        keccak_valid_o = accept;
        keccak_addr_o  = in_absorb ? word_cnt_q : '0;
        keccak_data_o  = in_absorb ? msg_data_i : '0;
        keccak_run_o   = (st_q == StRun) && keccak_ready_i;
        keccak_clear_o = (clear_req && clear_window && keccak_ready_i) ? MuBi4True : MuBi4False;
        digest_valid_o = (st_q == StDone) && !clear_i;
        busy_o         = !in_idle;
        error_o        = (st_q == StError);
        cmd_err_o      = cmd_err_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q          <= StIdle;
            word_cnt_q    <= '0;
            block_words_q <= '0;
            timer_q       <= '0;
            last_seen_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            clear_pend_q  <= 1'b0;
        end else begin
            cmd_err_q <= cmd_illegal;
            if (|keccak_err_i) begin
                st_q         <= StError;
                clear_pend_q <= 1'b0;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        clear_pend_q <= clear_req && !keccak_ready_i;
                        if (start_i && !clear_i && !clear_pend_q && rate_ok) begin
                            block_words_q <= block_words_i;
                            word_cnt_q    <= '0;
                            last_seen_q   <= 1'b0;
                            st_q          <= StAbsorb;
                        end
                    end
                    StAbsorb: begin
                        if (block_end) begin
                            last_seen_q <= last_seen_q || msg_last_i;
                            st_q        <= StRun;
                        end else if (accept) begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                    StRun: begin
                        if (keccak_ready_i) begin
                            word_cnt_q <= '0;
                            timer_q    <= '0;
                            st_q       <= StWait;
                        end
                    end
                    StWait: begin
                        timer_q <= timer_q + 1'b1;
                        if (keccak_complete_i) begin
                            st_q <= last_seen_q ? StDone : StAbsorb;
                        end else if (timer_q == TimerLast) begin
                            st_q <= StError;
                        end
                    end
                    StDone: begin
                        if (clear_i) begin
                            clear_pend_q <= !keccak_ready_i;
                            st_q         <= StIdle;
                        end
                    end
                    StError: begin
                        st_q <= StError;
                    end
                    default: begin
                        st_q <= StError;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Randomized scoreboard bench for keccak_absorb_ctrl with a behavioural message model
// and a stub keccak_round that answers run pulses with a delayed complete.
module tb_keccak_absorb_ctrl;
    import keccak_absorb_ctrl_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 64;
    localparam int K_WRITE = 0;
    localparam int K_RUN   = 1;
    localparam int K_CLEAR = 2;
    localparam int K_CMD   = 3;

    typedef struct {
        int          kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] block_words_i;
    logic          msg_valid_i;
    logic [DW-1:0] msg_data_i;
    logic          msg_last_i;
    logic          msg_ready_o;
    logic          clear_i;
    logic          digest_valid_o;
    logic          busy_o;
    logic          cmd_err_o;
    logic          error_o;
    logic          keccak_valid_o;
    logic [AW-1:0] keccak_addr_o;
    logic [DW-1:0] keccak_data_o;
    logic          keccak_ready_i;
    logic          keccak_run_o;
    logic          keccak_complete_i;
    mubi4_t        keccak_clear_o;
    logic [2:0]    keccak_err_i;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    ev_t         exp_q[$];
    bit          blocked = 1'b0;
    bit          hang = 1'b0;

    keccak_absorb_ctrl #(.Width(1600), .DInWidth(64), .TimeoutCyc(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .block_words_i(block_words_i),
        .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
        .msg_ready_o(msg_ready_o), .clear_i(clear_i), .digest_valid_o(digest_valid_o),
        .busy_o(busy_o), .cmd_err_o(cmd_err_o), .error_o(error_o),
        .keccak_valid_o(keccak_valid_o), .keccak_addr_o(keccak_addr_o),
        .keccak_data_o(keccak_data_o), .keccak_ready_i(keccak_ready_i),
        .keccak_run_o(keccak_run_o), .keccak_complete_i(keccak_complete_i),
        .keccak_clear_o(keccak_clear_o), .keccak_err_i(keccak_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d addr %0d, expected none at %0t", kind, addr, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", DW'(kind), DW'(e.kind));
            if (kind == K_WRITE && e.kind == K_WRITE) begin
                chk("write_addr", DW'(addr), DW'(e.addr));
                chk("write_data", data, e.data);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (cmd_err_o) pop_check(K_CMD, '0, '0);
            if (keccak_valid_o && keccak_run_o) begin
                vectors++;
                miscompares++;
                $display("FAIL valid_run_overlap: got both high, expected at most one at %0t", $time);
            end
            if (keccak_valid_o) pop_check(K_WRITE, keccak_addr_o, keccak_data_o);
            if (keccak_run_o) begin
                pop_check(K_RUN, '0, '0);
                chk("run_needs_ready", DW'(keccak_ready_i), DW'(1));
            end
            if (keccak_clear_o != MuBi4False) begin
                pop_check(K_CLEAR, '0, '0);
                chk("clear_value", DW'(keccak_clear_o), DW'(MuBi4True));
                chk("clear_needs_ready", DW'(keccak_ready_i), DW'(1));
            end
        end
    end

    // Stub permutation core: one complete pulse a few cycles after each run.
    initial begin
        int unsigned lat;
        keccak_complete_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (keccak_run_o === 1'b1 && !rst_i && !hang) begin
                lat = $urandom_range(1, 20);
                repeat (lat) @(posedge clk_i);
                #1 keccak_complete_i = 1'b1;
                @(posedge clk_i);
                #1 keccak_complete_i = 1'b0;
                blocked = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0; block_words_i = '0; msg_valid_i = 1'b0; msg_data_i = '0;
        msg_last_i = 1'b0; clear_i = 1'b0; keccak_ready_i = 1'b1; keccak_err_i = '0;
        blocked = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_msg_ready", DW'(msg_ready_o), DW'(0));
        chk("rst_digest_valid", DW'(digest_valid_o), DW'(0));
        chk("rst_busy", DW'(busy_o), DW'(0));
        chk("rst_cmd_err", DW'(cmd_err_o), DW'(0));
        chk("rst_error", DW'(error_o), DW'(0));
        chk("rst_kvalid", DW'(keccak_valid_o), DW'(0));
        chk("rst_kaddr", DW'(keccak_addr_o), DW'(0));
        chk("rst_kdata", keccak_data_o, '0);
        chk("rst_krun", DW'(keccak_run_o), DW'(0));
        chk("rst_kclear", DW'(keccak_clear_o), DW'(MuBi4False));
    endtask

    task automatic do_start(input int unsigned rate, input bit legal);
        if (!legal) push(K_CMD, '0, '0);
        start_i = 1'b1;
        block_words_i = AW'(rate);
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_start", DW'(busy_o), DW'(legal));
        @(posedge clk_i);
        #1;
    endtask

    // Message model: word i lands in lane i mod rate; a run follows every full block and the last word.
    task automatic send_msg(input int unsigned rate, input int unsigned n, input bit with_last);
        logic [DW-1:0] d;
        bit blk_end, acc, exp_rdy;
        int unsigned guard;
        for (int unsigned i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            blk_end = ((i % rate) == rate - 1) || (with_last && i == n - 1);
            if ($urandom_range(0, 3) == 0) begin
                msg_valid_i = 1'b0;
                keccak_ready_i = ($urandom_range(0, 3) != 0);
                @(posedge clk_i);
                #1;
            end
            msg_valid_i = 1'b1;
            msg_data_i = d;
            msg_last_i = with_last && (i == n - 1);
            push(K_WRITE, AW'(i % rate), d);
            if (blk_end) push(K_RUN, '0, '0);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 300) begin
                keccak_ready_i = ($urandom_range(0, 3) != 0);
                @(negedge clk_i);
                exp_rdy = !blocked && keccak_ready_i;
                chk("msg_ready", DW'(msg_ready_o), DW'(exp_rdy));
                acc = msg_ready_o;
                @(posedge clk_i);
                #1;
                guard++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL word_accept_timeout: got no accept, expected word %0d taken", i);
                msg_valid_i = 1'b0;
                return;
            end
            if (blk_end) blocked = 1'b1;
        end
        msg_valid_i = 1'b0;
        msg_last_i = 1'b0;
        keccak_ready_i = 1'b1;
    endtask

    task automatic finish_msg();
        int unsigned guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!digest_valid_o && guard < 200);
        chk("digest_valid", DW'(digest_valid_o), DW'(1));
        chk("busy_in_done", DW'(busy_o), DW'(1));
        @(posedge clk_i);
        #1 clear_i = 1'b1;
        push(K_CLEAR, '0, '0);
        @(negedge clk_i);
        chk("digest_drop_on_clear", DW'(digest_valid_o), DW'(0));
        @(posedge clk_i);
        #1 clear_i = 1'b0;
        @(negedge clk_i);
        chk("idle_after_clear", DW'(busy_o), DW'(0));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int unsigned rate, n, guard;
        do_reset();
        @(negedge clk_i);
        check_reset_values();
        @(posedge clk_i);
        #1;

        do_start(17, 1'b1); send_msg(17, 17, 1'b1); finish_msg();
        do_start(17, 1'b1); send_msg(17, 34, 1'b1); finish_msg();
        do_start(17, 1'b1); send_msg(17, 5, 1'b1);  finish_msg();
        do_start(1, 1'b1);  send_msg(1, 3, 1'b1);   finish_msg();
        do_start(25, 1'b1); send_msg(25, 26, 1'b1); finish_msg();
        repeat (6) begin
            rate = $urandom_range(1, 25);
            n = $urandom_range(1, 3 * rate);
            do_start(rate, 1'b1); send_msg(rate, n, 1'b1); finish_msg();
        end

        // Commands while idle.
        clear_i = 1'b1; push(K_CLEAR, '0, '0);
        @(posedge clk_i); #1 clear_i = 1'b0;
        @(negedge clk_i); chk("idle_clear_stays_idle", DW'(busy_o), DW'(0));
        @(posedge clk_i); #1;
        clear_i = 1'b1; start_i = 1'b1; block_words_i = 5'd4;
        push(K_CLEAR, '0, '0); push(K_CMD, '0, '0);
        @(posedge clk_i); #1 clear_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i); chk("clear_beats_start", DW'(busy_o), DW'(0));
        @(posedge clk_i); #1;
        do_start(0, 1'b0);
        do_start(26, 1'b0);

        // Illegal commands mid-absorb, then a permutation error.
        do_start(5, 1'b1); send_msg(5, 2, 1'b0);
        push(K_CMD, '0, '0); start_i = 1'b1; block_words_i = 5'd3;
        @(posedge clk_i); #1 start_i = 1'b0;
        push(K_CMD, '0, '0); clear_i = 1'b1;
        @(posedge clk_i); #1 clear_i = 1'b0; keccak_err_i = 3'b010;
        @(posedge clk_i); #1 keccak_err_i = '0; msg_valid_i = 1'b1; msg_data_i = 64'hDEAD_BEEF;
        @(negedge clk_i);
        chk("err_in_to_error", DW'(error_o), DW'(1));
        chk("err_no_ready", DW'(msg_ready_o), DW'(0));
        @(posedge clk_i); #1 msg_valid_i = 1'b0;
        do_reset();

        // Reset in the middle of a block.
        do_start(17, 1'b1); send_msg(17, 3, 1'b0);
        msg_valid_i = 1'b1; msg_data_i = {$urandom, $urandom}; keccak_ready_i = 1'b1;
        rst_i = 1'b1;
        #1 check_reset_values();
        do_reset();

        // Timeout: the core never completes.
        hang = 1'b1;
        do_start(4, 1'b1); send_msg(4, 2, 1'b1);
        guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!keccak_run_o && guard < 50);
        chk("timeout_run_seen", DW'(keccak_run_o), DW'(1));
        repeat (64) @(negedge clk_i);
        chk("no_error_before_timeout", DW'(error_o), DW'(0));
        @(negedge clk_i);
        chk("error_at_timeout", DW'(error_o), DW'(1));
        @(posedge clk_i); #1;
        push(K_CMD, '0, '0); start_i = 1'b1; block_words_i = 5'd17;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("error_sticky", DW'(error_o), DW'(1));
        chk("error_no_digest", DW'(digest_valid_o), DW'(0));
        hang = 1'b0;
        do_reset();

        repeat (4) @(posedge clk_i);
        chk("scoreboard_drained", DW'(exp_q.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
